mode_control: RTL and testbench

Front-end control stage for the LED-pattern processors. It synchronizes and debounces the raw pause and mode buttons, and maintains the pause toggle and the 2-bit mode select. It generates the periodic step `tick` and a one-cycle `mode_reset` pulse. Its `tick`/`pause` outputs drive the `tick`/`pause` inputs of every mode processor. `mode` drives the downstream LED output mux.

---
 rtl/mode_control.sv | 103 ++++++++++
 tb/tb_mode_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_control.sv
// Button front end for the LED-pattern processors: synchronizes and debounces
// the pause/mode buttons, tracks pause and mode, and produces the step tick.
module mode_control #(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_mode,
    output logic       tick,
    output logic       pause,
    output logic [1:0] mode,
    output logic       mode_reset
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = pause button, bit 1 = mode button.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_mode, btn_pause};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            meta_reg;
            logic            s_reg;
            logic            stable_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg   <= 1'b0;
                    s_reg      <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    s_reg    <= meta_reg;
                    if (s_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg != DB_LAST) begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end else begin
                        stable_reg <= s_reg;
                        cnt_reg    <= '0;
                    end
                end
            end

            // A press is the edge on which the stable level is accepted as 1.
            assign press[gi] = s_reg && !stable_reg && (cnt_reg == DB_LAST);
        end
    endgenerate

    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg, tick_next;
    logic             pause_reg, pause_next;
    logic [1:0]       mode_reg, mode_next;
    logic             mode_reset_reg, mode_reset_next;

    always_comb begin
        div_next        = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        tick_next       = (div_reg == DIV_LAST);
        pause_next      = pause_reg ^ press[0];
        mode_next       = mode_reg;
        mode_reset_next = 1'b0;
        // A mode change restarts the processors and the step period, and beats a same-edge pause press.
        if (press[1]) begin
            mode_next       = mode_reg + 2'd1;
            pause_next      = 1'b0;
            mode_reset_next = 1'b1;
            div_next        = '0;
            tick_next       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg        <= '0;
            tick_reg       <= 1'b0;
            pause_reg      <= 1'b0;
            mode_reg       <= 2'd0;
            mode_reset_reg <= 1'b0;
        end else begin
            div_reg        <= div_next;
            tick_reg       <= tick_next;
            pause_reg      <= pause_next;
            mode_reg       <= mode_next;
            mode_reset_reg <= mode_reset_next;
        end
    end

    assign tick       = tick_reg;
    assign pause      = pause_reg;
    assign mode       = mode_reg;
    assign mode_reset = mode_reset_reg;

endmodule

// File: tb/tb_mode_control.sv
// Directed bench for mode_control with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_mode_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_pause;
    logic       btn_mode;
    logic       tick;
    logic       pause;
    logic [1:0] mode;
    logic       mode_reset;

    int checks = 0;
    int errors = 0;

    mode_control #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_mode(btn_mode),
        .tick(tick), .pause(pause), .mode(mode), .mode_reset(mode_reset)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; btn_pause = 1'b0; btn_mode = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    // Hold a button long enough to register, then release until it settles low.
    task automatic press_btn(input bit use_mode);
        if (use_mode) btn_mode = 1'b1; else btn_pause = 1'b1;
        repeat (5) step();
        btn_mode = 1'b0; btn_pause = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tick, pause, mode, mode_reset} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got tick=%b pause=%b mode=%0d mode_reset=%b, want all 0", tick, pause, mode, mode_reset);
        end
        $display("reset_state: tick=%b pause=%b mode=%0d mode_reset=%b", tick, pause, mode, mode_reset);
    endtask

    task automatic test_tick();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (tick !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL tick_edge%0d: got %b want %b", k, tick, (k % 4 == 0));
            end
            checks++;
            if ({pause, mode, mode_reset} !== 4'b0) begin
                errors++;
                $display("FAIL idle_outputs_edge%0d: got pause=%b mode=%0d mode_reset=%b want 0", k, pause, mode, mode_reset);
            end
        end
        $display("tick: 20 idle edges done");
    endtask

    task automatic test_pause();
        do_reset();
        btn_pause = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (pause !== (k >= 5)) begin
                errors++;
                $display("FAIL pause_press1_edge%0d: got %b want %b", k, pause, (k >= 5));
            end
        end
        btn_pause = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (pause !== 1'b1) begin
                errors++;
                $display("FAIL pause_release_edge%0d: got %b want 1", k, pause);
            end
        end
        btn_pause = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (pause !== (k < 5)) begin
                errors++;
                $display("FAIL pause_press2_edge%0d: got %b want %b", k, pause, (k < 5));
            end
        end
        btn_pause = 1'b0;
        repeat (6) step();
        $display("pause: press/release/press done, pause=%b", pause);
    endtask

    task automatic test_bounce();
        logic [8:0] pattern;
        logic [11:0] pulses;
        pattern = 9'b111101101; // bit k-1 is applied before edge k: 1,0,1,1,0,1,1,1,1
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            btn_pause = (k <= 9) ? pattern[k-1] : 1'b1;
            step();
            checks++;
            if (pause !== (k >= 10)) begin
                errors++;
                $display("FAIL bounce_edge%0d: got %b want %b", k, pause, (k >= 10));
            end
        end
        btn_pause = 1'b0;
        repeat (8) step();
        pulses = 12'b010101001001;
        for (int k = 0; k < 12; k++) begin
            btn_pause = pulses[k];
            step();
            checks++;
            if (pause !== 1'b1) begin
                errors++;
                $display("FAIL glitch_edge%0d: got %b want 1", k, pause);
            end
        end
        btn_pause = 1'b0;
        repeat (6) step();
        $display("bounce: one toggle, glitches ignored, pause=%b", pause);
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode;
        do_reset();
        press_btn(1'b0);
        exp_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            btn_mode = 1'b1;
            repeat (4) step();
            checks++;
            if (mode !== exp_mode || mode_reset !== 1'b0) begin
                errors++;
                $display("FAIL mode_pre%0d: got mode=%0d mode_reset=%b want mode=%0d mode_reset=0", i, mode, mode_reset, exp_mode);
            end
            if (i == 0) begin
                checks++;
                if (pause !== 1'b1) begin
                    errors++;
                    $display("FAIL pause_before_mode: got %b want 1", pause);
                end
            end
            step();
            exp_mode = exp_mode + 2'd1;
            checks++;
            if (mode !== exp_mode || pause !== 1'b0 || mode_reset !== 1'b1 || tick !== 1'b0) begin
                errors++;
                $display("FAIL mode_press%0d: got mode=%0d pause=%b mode_reset=%b tick=%b want mode=%0d pause=0 mode_reset=1 tick=0", i, mode, pause, mode_reset, tick, exp_mode);
            end
            btn_mode = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                step();
                checks++;
                if (mode_reset !== 1'b0 || tick !== (k == 4) || mode !== exp_mode) begin
                    errors++;
                    $display("FAIL mode_after%0d_edge%0d: got mode_reset=%b tick=%b mode=%0d want 0 %b %0d", i, k, mode_reset, tick, mode, (k == 4), exp_mode);
                end
            end
            repeat (4) step();
            $display("mode_cycle: press %0d mode=%0d", i, mode);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_pause = 1'b1; btn_mode = 1'b1;
        repeat (4) step();
        step();
        checks++;
        if (mode !== 2'd1 || pause !== 1'b0 || mode_reset !== 1'b1) begin
            errors++;
            $display("FAIL simul_press: got mode=%0d pause=%b mode_reset=%b want 1 0 1", mode, pause, mode_reset);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (mode !== 2'd1 || pause !== 1'b0 || mode_reset !== 1'b0) begin
                errors++;
                $display("FAIL simul_hold_edge%0d: got mode=%0d pause=%b mode_reset=%b want 1 0 0", k, mode, pause, mode_reset);
            end
        end
        btn_pause = 1'b0; btn_mode = 1'b0;
        repeat (6) step();
        $display("simultaneous: mode=%0d pause=%b", mode, pause);
    endtask

    task automatic test_reset_midway();
        bit seen;
        do_reset();
        press_btn(1'b1);
        press_btn(1'b1);
        press_btn(1'b0);
        checks++;
        if (mode !== 2'd2 || pause !== 1'b1) begin
            errors++;
            $display("FAIL midway_setup: got mode=%0d pause=%b want 2 1", mode, pause);
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = tick;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midway_tick_wait: got no tick in 8 edges, want one");
        end
        repeat (2) step();
        btn_pause = 1'b1;
        repeat (4) step();
        checks++;
        if (pause !== 1'b1 || mode !== 2'd2 || tick !== 1'b0) begin
            errors++;
            $display("FAIL midway_state: got pause=%b mode=%0d tick=%b want 1 2 0", pause, mode, tick);
        end
        reset = 1'b1; btn_pause = 1'b0;
        step();
        checks++;
        if ({tick, pause, mode, mode_reset} !== 5'b0) begin
            errors++;
            $display("FAIL midway_reset: got tick=%b pause=%b mode=%0d mode_reset=%b want all 0", tick, pause, mode, mode_reset);
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (tick !== (k % 4 == 0) || {pause, mode, mode_reset} !== 4'b0) begin
                errors++;
                $display("FAIL after_reset_edge%0d: got tick=%b pause=%b mode=%0d mode_reset=%b want tick=%b rest 0", k, tick, pause, mode, mode_reset, (k % 4 == 0));
            end
        end
        $display("reset_midway: outputs cleared, no spurious press");
    endtask

    initial begin
        reset = 1'b1; btn_pause = 1'b0; btn_mode = 1'b0;
        test_reset();
        test_tick();
        test_pause();
        test_bounce();
        test_mode_cycle();
        test_simultaneous();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
